reg_dump_reader: RTL and testbench
==================================

REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 The block SHALL have parameter WORD_LEN, default 32, meaning register data width.
REQ-002 The block SHALL have parameter REG_FILE_ADDR_LEN, default 4, meaning register address width.
REQ-003 The block SHALL have parameter REG_FILE_SIZE, default 16, meaning number of registers (at most 2^REG_FILE_ADDR_LEN).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request a dump sweep; sampled only in IDLE.
REQ-007 abort  input  1  terminate the current sweep.
REQ-008 first_addr, last_addr  input  REG_FILE_ADDR_LEN each  inclusive sweep bounds, latched on accepted start.
REQ-009 rf_addr  output  REG_FILE_ADDR_LEN  register-file read port address.
REQ-010 rf_data  input  WORD_LEN  register-file read data, combinational from rf_addr.
REQ-011 out_valid  output  1;  out_ready  input  1  stream handshake.
REQ-012 out_data  output  WORD_LEN;  out_addr  output  REG_FILE_ADDR_LEN  word payload and its source address.
REQ-013 busy  output  1  sweep in progress;  done  output  1  one-cycle completion pulse.
REQ-014 word_count  output  REG_FILE_ADDR_LEN+1  words transferred in the current/last sweep.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, SEND, DONE.
REQ-016 IDLE: start=1 and abort=0 SHALL latch bounds, set cur=first_addr, clear word_count, go to FETCH next cycle.
REQ-017 start SHALL be ignored in every state except IDLE.
REQ-018 FETCH: rf_addr=cur; at clock edge out_data<=rf_data, out_addr<=cur; go to SEND.
REQ-019 SEND: out_valid=1; out_data/out_addr SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 SEND with out_ready=1: word_count increments; if cur==last go to DONE, else cur<=next(cur) and go to FETCH.
REQ-021 next(cur) SHALL be cur+1, wrapping REG_FILE_SIZE-1 -> 0.
REQ-022 first_addr > last_addr SHALL sweep first..REG_FILE_SIZE-1 then 0..last (wrap-around sweep).
REQ-023 first_addr == last_addr SHALL transfer exactly one word.
REQ-024 Bounds >= REG_FILE_SIZE SHALL be reduced modulo REG_FILE_SIZE on latch.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE.
REQ-026 Throughput SHALL be one word per 2 cycles with out_ready held high; first out_valid 2 cycles after start accepted.
REQ-027 abort=1 in FETCH/SEND/DONE SHALL force IDLE next cycle; no done pulse; word_count holds value at abort.
REQ-028 A SEND handshake coinciding with abort SHALL count as transferred (word_count increments).
REQ-029 start and abort together in IDLE: abort wins, remain IDLE.
REQ-030 busy SHALL be 1 in FETCH, SEND, DONE; 0 in IDLE.
REQ-031 out_valid SHALL be 1 only in SEND; rf_addr SHALL equal cur in all states.
REQ-032 The block SHALL never write the register file; rf_data changes outside FETCH SHALL not affect captured data.

Reset
REQ-033 rst=0 at a rising edge SHALL force IDLE, cur=0, rf_addr=0, out_data=0, out_addr=0, word_count=0, out_valid=0, busy=0, done=0.
REQ-034 Reset mid-sweep SHALL abandon the sweep with no done pulse; start during rst=0 SHALL be ignored.

Verification
REQ-035 Registers r[i]=0x100+i, start with first=2, last=5, out_ready=1 -> words 0x102..0x105, out_addr 2..5, done 1 cycle, word_count=4.
REQ-036 first=14, last=1 -> out_addr sequence 14,15,0,1, word_count=4, done asserted.
REQ-037 first=last=7, out_ready low 5 cycles in SEND -> out_valid held, out_data=0x107 stable, one word, done after ready.
REQ-038 first=0, last=15, abort after 3rd handshake -> IDLE next cycle, no done, word_count=3, busy=0.
REQ-039 rst low during SEND of sweep 0..15 -> all outputs zero next edge; new start after rst high sweeps normally.
REQ-040 start pulsed again while busy, and start+abort in IDLE -> both ignored, sweep/IDLE unaffected.

Source files
------------

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: sweeps an inclusive address range of a register file
// (optionally wrapping past the top) and streams each word out over a
// valid/ready handshake, one word per two cycles when the sink never stalls.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   start, abort             begin a sweep (IDLE only) / terminate a sweep
//   first_addr, last_addr    inclusive sweep bounds, latched on accepted start
//   rf_addr, rf_data         register-file read port (data combinational)
//   out_valid, out_ready     output stream handshake
//   out_data, out_addr       captured word and its source address
//   busy, done, word_count   status: sweep active, completion pulse, words sent
module reg_dump_reader #(
  parameter int unsigned WORD_LEN          = 32,
  parameter int unsigned REG_FILE_ADDR_LEN = 4,
  parameter int unsigned REG_FILE_SIZE     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [REG_FILE_ADDR_LEN-1:0]   first_addr,
  input  logic [REG_FILE_ADDR_LEN-1:0]   last_addr,
  output logic [REG_FILE_ADDR_LEN-1:0]   rf_addr,
  input  logic [WORD_LEN-1:0]            rf_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WORD_LEN-1:0]            out_data,
  output logic [REG_FILE_ADDR_LEN-1:0]   out_addr,
  output logic                           busy,
  output logic                           done,
  output logic [REG_FILE_ADDR_LEN:0]     word_count
);

  localparam int unsigned AW = REG_FILE_ADDR_LEN;
  localparam int unsigned DW = WORD_LEN;
  localparam int unsigned CW = REG_FILE_ADDR_LEN + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cur_q, cur_d;
  logic [AW-1:0]   last_q, last_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [AW-1:0]   out_addr_q, out_addr_d;
  logic [CW-1:0]   word_count_q, word_count_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            start_ok_c;
  logic            handshake_c;
  logic            at_last_c;

  // Bring an out-of-range bound back into the register file.
  function automatic logic [AW-1:0] reduce_addr(input logic [AW-1:0] a);
    return AW'(32'(a) % REG_FILE_SIZE);
  endfunction

  // Successor address, wrapping the top register back to zero.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (32'(a) == REG_FILE_SIZE - 1) ? '0 : a + AW'(1);
  endfunction

  assign start_ok_c  = start && !abort;
  assign handshake_c = (state_q == S_SEND) && out_ready;
  assign at_last_c   = (cur_q == last_q);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; abort beats everything outside IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok_c) state_d = S_FETCH;
      S_FETCH: state_d = abort ? S_IDLE : S_SEND;
      S_SEND: begin
        if (abort)            state_d = S_IDLE;
        else if (out_ready)   state_d = at_last_c ? S_DONE : S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs, decoded from the upcoming state.
  always_comb begin
    cur_d        = cur_q;
    last_d       = last_q;
    out_data_d   = out_data_q;
    out_addr_d   = out_addr_q;
    word_count_d = word_count_q;
    out_valid_d  = (state_d == S_SEND);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);

    unique case (state_q)
      S_IDLE: begin
        if (start_ok_c) begin
          cur_d        = reduce_addr(first_addr);
          last_d       = reduce_addr(last_addr);
          word_count_d = '0;
        end
      end
      S_FETCH: begin
        out_data_d = rf_data;
        out_addr_d = cur_q;
      end
      S_SEND: begin
        // A handshake that coincides with abort still counts as delivered.
        if (handshake_c) begin
          word_count_d = word_count_q + CW'(1);
          if (!abort && !at_last_c) cur_d = next_addr(cur_q);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_q        <= '0;
      last_q       <= '0;
      out_data_q   <= '0;
      out_addr_q   <= '0;
      word_count_q <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      cur_q        <= cur_d;
      last_q       <= last_d;
      out_data_q   <= out_data_d;
      out_addr_q   <= out_addr_d;
      word_count_q <= word_count_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rf_addr    = cur_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign word_count = word_count_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: register file model r[i] = base + i.
module tb_reg_dump_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          busy;
  logic          done;
  logic [AW:0]   word_count;

  logic [DW-1:0] rf_base;

  int checks;
  int errors;

  // Monitor results filled by collect().
  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_data[$];
  int            done_cnt;
  logic          timed_out;

  reg_dump_reader #(
    .WORD_LEN(DW),
    .REG_FILE_ADDR_LEN(AW),
    .REG_FILE_SIZE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .first_addr(first_addr),
    .last_addr(last_addr),
    .rf_addr(rf_addr),
    .rf_data(rf_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_addr(out_addr),
    .busy(busy),
    .done(done),
    .word_count(word_count)
  );

  assign rf_data = rf_base + 32'(rf_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Record handshakes and done pulses until busy falls, bounded.
  task automatic collect(input int max_cycles);
    got_addr.delete();
    got_data.delete();
    done_cnt  = 0;
    timed_out = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      if (out_valid && out_ready) begin
        got_addr.push_back(out_addr);
        got_data.push_back(out_data);
      end
      if (done) done_cnt++;
      cyc();
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    cyc();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc();
    cyc();
    checks++;
    if ({out_valid, busy, done, rf_addr, out_addr, word_count, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b busy=%0b done=%0b rf_addr=%0d out_addr=%0d wc=%0d data=%h, required all zero",
               out_valid, busy, done, rf_addr, out_addr, word_count, out_data);
    end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    pulse_start(4'd2, 4'd5);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || rf_addr !== 4'd2) begin
      errors++;
      $display("FAIL basic_fetch0: busy=%0b valid=%0b rf_addr=%0d, required 1 0 2", busy, out_valid, rf_addr);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h102 + 32'(k) || out_addr !== 4'(2 + k)) begin
        errors++;
        $display("FAIL basic_word%0d: valid=%0b data=%h addr=%0d, required 1 %h %0d",
                 k, out_valid, out_data, out_addr, 32'h102 + 32'(k), 2 + k);
      end
      cyc();
    end
    checks++;
    if (done !== 1'b1 || word_count !== 5'd4 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%0b wc=%0d valid=%0b, required 1 4 0", done, word_count, out_valid);
    end
    cyc();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || word_count !== 5'd4) begin
      errors++;
      $display("FAIL basic_idle: done=%0b busy=%0b wc=%0d, required 0 0 4", done, busy, word_count);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [4];
    exp_a = '{4'd14, 4'd15, 4'd0, 4'd1};
    out_ready = 1'b1;
    pulse_start(4'd14, 4'd1);
    collect(50);
    checks++;
    if (timed_out || got_addr.size() != 4 || done_cnt != 1 || word_count !== 5'd4) begin
      errors++;
      $display("FAIL wrap_summary: timeout=%0b words=%0d done_pulses=%0d wc=%0d, required 0 4 1 4",
               timed_out, got_addr.size(), done_cnt, word_count);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got_addr[k] !== exp_a[k] || got_data[k] !== 32'h100 + 32'(exp_a[k])) begin
          errors++;
          $display("FAIL wrap_word%0d: addr=%0d data=%h, required %0d %h",
                   k, got_addr[k], got_data[k], exp_a[k], 32'h100 + 32'(exp_a[k]));
        end
      end
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    pulse_start(4'd7, 4'd7);
    cyc();
    // Register file contents move while the word waits; capture must hold.
    rf_base = 32'h900;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h107 || out_addr !== 4'd7 || done !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%0b data=%h addr=%0d done=%0b, required 1 00000107 7 0",
                 k, out_valid, out_data, out_addr, done);
      end
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    checks++;
    if (done !== 1'b1 || word_count !== 5'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: done=%0b wc=%0d valid=%0b, required 1 1 0", done, word_count, out_valid);
    end
    cyc();
    rf_base = 32'h100;
  endtask

  task automatic test_abort();
    int hs;
    hs = 0;
    out_ready = 1'b1;
    pulse_start(4'd0, 4'd15);
    for (int i = 0; i < 40; i++) begin
      if (out_valid && out_ready) hs++;
      if (hs == 3) begin
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        break;
      end
      cyc();
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || word_count !== 5'd3) begin
      errors++;
      $display("FAIL abort_state: busy=%0b valid=%0b done=%0b wc=%0d, required 0 0 0 3",
               busy, out_valid, done, word_count);
    end
    for (int i = 0; i < 3; i++) cyc();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || word_count !== 5'd3) begin
      errors++;
      $display("FAIL abort_quiet: busy=%0b done=%0b wc=%0d, required 0 0 3", busy, done, word_count);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    pulse_start(4'd0, 4'd15);
    cyc();
    cyc();
    cyc();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rmid_in_send: valid=%0b, required 1", out_valid);
    end
    rst   = 1'b0;
    start = 1'b1;
    cyc();
    checks++;
    if ({out_valid, busy, done, rf_addr, out_addr, word_count, out_data} !== '0) begin
      errors++;
      $display("FAIL rmid_zero: valid=%0b busy=%0b done=%0b rf_addr=%0d out_addr=%0d wc=%0d data=%h, required all zero",
               out_valid, busy, done, rf_addr, out_addr, word_count, out_data);
    end
    cyc();
    rst   = 1'b1;
    start = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_start_ignored: busy=%0b, required 0", busy);
    end
    pulse_start(4'd3, 4'd4);
    collect(30);
    checks++;
    if (timed_out || got_addr.size() != 2 || done_cnt != 1 || word_count !== 5'd2) begin
      errors++;
      $display("FAIL rmid_resweep: timeout=%0b words=%0d done_pulses=%0d wc=%0d, required 0 2 1 2",
               timed_out, got_addr.size(), done_cnt, word_count);
    end else begin
      checks++;
      if (got_addr[0] !== 4'd3 || got_data[0] !== 32'h103 || got_addr[1] !== 4'd4 || got_data[1] !== 32'h104) begin
        errors++;
        $display("FAIL rmid_words: %0d/%h %0d/%h, required 3/00000103 4/00000104",
                 got_addr[0], got_data[0], got_addr[1], got_data[1]);
      end
    end
  endtask

  task automatic test_ignored_start();
    out_ready = 1'b1;
    pulse_start(4'd2, 4'd3);
    first_addr = 4'd9;
    last_addr  = 4'd12;
    start      = 1'b1;
    cyc();
    cyc();
    start = 1'b0;
    collect(30);
    checks++;
    if (timed_out || got_addr.size() != 1 || done_cnt != 1 || word_count !== 5'd2) begin
      errors++;
      $display("FAIL busy_start: timeout=%0b words=%0d done_pulses=%0d wc=%0d, required 0 1 1 2",
               timed_out, got_addr.size(), done_cnt, word_count);
    end else begin
      checks++;
      if (got_addr[0] !== 4'd3 || got_data[0] !== 32'h103) begin
        errors++;
        $display("FAIL busy_start_word: %0d/%h, required 3/00000103", got_addr[0], got_data[0]);
      end
    end
    start = 1'b1;
    abort = 1'b1;
    cyc();
    cyc();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || word_count !== 5'd2) begin
      errors++;
      $display("FAIL start_abort_idle: busy=%0b valid=%0b wc=%0d, required 0 0 2", busy, out_valid, word_count);
    end
    start = 1'b0;
    abort = 1'b0;
    cyc();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    first_addr = '0;
    last_addr  = '0;
    out_ready  = 1'b0;
    rf_base    = 32'h100;
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_abort();
    test_reset_mid();
    test_ignored_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
